imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage of the RV32IM/RV64 core.
- Accepts a raw instruction and an immediate-select code over a valid/ready handshake.
- Produces the XLEN-wide sign- or zero-extended immediate one cycle later, together with a pass-through tag and an illegal-format flag.
- Contains a 2-entry skid buffer, so `in_ready` is a register output and decode can be retimed without combinational ready paths.

---
 rtl/imm_gen_pkg.sv | 62 ++++++
 rtl/imm_skid_buf.sv | 86 ++++++++
 rtl/imm_gen_pipe.sv | 60 ++++++
 tb/tb_imm_gen_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Immediate-format definitions shared by the decode-stage immediate generator.
// Holds the select encoding, the skid buffer state type and the pure
// immediate builder used on the input side of imm_gen_pipe.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    SEL_I   = 3'b000,
    SEL_S   = 3'b001,
    SEL_B   = 3'b010,
    SEL_J   = 3'b011,
    SEL_U   = 3'b100,
    SEL_Z   = 3'b101,
    SEL_SH  = 3'b110,
    SEL_RSV = 3'b111
  } imm_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Widest supported datapath; narrower XLEN takes the low bits.
  localparam int IMM_MAX_W = 64;

  // Returns {illegal, imm[63:0]}. The immediate is always built at 64 bits;
  // truncating a sign-extended value to 32 bits is still the correct 32-bit
  // result, so only the shamt legality check depends on xlen.
  function automatic logic [IMM_MAX_W:0] build_imm(
    input logic [31:0] ins,
    input imm_sel_e    sel,
    input int unsigned xlen
  );
    logic [IMM_MAX_W-1:0] imm;
    logic                 ill;
    imm = '0;
    ill = 1'b0;
    case (sel)
      SEL_I:  imm = {{52{ins[31]}}, ins[31:20]};
      SEL_S:  imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      SEL_B:  imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SEL_J:  imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      SEL_U:  imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      SEL_Z:  imm = {59'b0, ins[19:15]};
      SEL_SH: begin
        // A 6-bit shamt with the top bit set does not exist on RV32.
        if (xlen == 32 && ins[25]) begin
          ill = 1'b1;
          imm = {59'b0, ins[24:20]};
        end else begin
          imm = {58'b0, ins[25:20]};
        end
      end
      default: begin
        ill = 1'b1;
        imm = '0;
      end
    endcase
    return {ill, imm};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry skid buffer: main register M drives the output, K absorbs
// one extra beat so that o_ready is purely registered.
// Ports: clk/rst_n/flush; i_valid/o_ready/i_dat upstream; o_valid/i_ready/o_dat downstream.
module imm_skid_buf
  import imm_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_dat,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_dat
);

  skid_state_e r_state;
  logic [W-1:0] r_m;
  logic [W-1:0] r_k;
  logic         r_in_rdy;
  logic         r_out_vld;

  logic w_acc;
  logic w_xfer;

  assign w_acc  = i_valid & r_in_rdy;
  assign w_xfer = r_out_vld & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_m       <= '0;
      r_k       <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else if (flush) begin
      // Any beat presented or buffered this cycle is dropped; data registers
      // keep their contents since o_valid masks them.
      r_state   <= EMPTY;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_m       <= i_dat;
            r_state   <= ONE;
            r_out_vld <= 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_xfer) begin
            r_m <= i_dat;
          end else if (w_acc) begin
            r_k      <= i_dat;
            r_state  <= TWO;
            r_in_rdy <= 1'b0;
          end else if (w_xfer) begin
            r_state   <= EMPTY;
            r_out_vld <= 1'b0;
          end
        end
        TWO: begin
          if (w_xfer) begin
            r_m      <= r_k;
            r_state  <= ONE;
            r_in_rdy <= 1'b1;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_in_rdy;
  assign o_valid = r_out_vld;
  assign o_dat   = r_m;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for decode: builds the XLEN immediate from
// the raw instruction, then buffers {illegal, imm, tag} in a 2-entry skid buffer.
// Ports: clk/rst_n/flush; in_valid/in_ready/in_ins/in_sel/in_tag; out_valid/out_ready/out_imm/out_tag/out_illegal.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int PW = 1 + XLEN + TAG_W;

  logic [IMM_MAX_W:0] w_build;
  logic [PW-1:0]      w_in_dat;
  logic [PW-1:0]      w_out_dat;

  assign w_build  = build_imm(in_ins, imm_sel_e'(in_sel), XLEN);
  assign w_in_dat = {w_build[IMM_MAX_W], w_build[XLEN-1:0], in_tag};

  // Upper immediate bits are only meaningful for the 64-bit datapath.
  generate
    if (XLEN < IMM_MAX_W) begin : g_narrow
      logic w_unused_hi;
      assign w_unused_hi = ^w_build[IMM_MAX_W-1:XLEN];
    end
  endgenerate

  imm_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_dat   (w_in_dat),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_dat   (w_out_dat)
  );

  assign out_illegal = w_out_dat[PW-1];
  assign out_imm     = w_out_dat[TAG_W +: XLEN];
  assign out_tag     = w_out_dat[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (rdy32), .in_ins (in_ins),
    .in_sel (in_sel), .in_tag (in_tag),
    .out_valid (vld32), .out_ready (out_ready), .out_imm (imm32),
    .out_tag (tag32), .out_illegal (ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (rdy64), .in_ins (in_ins),
    .in_sel (in_sel), .in_tag (in_tag),
    .out_valid (vld64), .out_ready (out_ready), .out_imm (imm64),
    .out_tag (tag64), .out_illegal (ill64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat at a negedge; returns at the next negedge with in_valid low.
  task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [4:0] tag);
    in_valid = 1'b1;
    in_ins   = ins;
    in_sel   = sel;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Single beat with out_ready=1: check both widths one cycle later, then drain.
  task automatic vec(input string name, input logic [31:0] ins, input logic [2:0] sel,
                     input logic [4:0] tag, input logic [31:0] e32, input logic e_ill32,
                     input logic [63:0] e64, input logic e_ill64);
    out_ready = 1'b1;
    send(ins, sel, tag);
    chk({name, "_vld32"}, {63'b0, vld32}, 64'd1);
    chk({name, "_imm32"}, {32'b0, imm32}, {32'b0, e32});
    chk({name, "_ill32"}, {63'b0, ill32}, {63'b0, e_ill32});
    chk({name, "_tag32"}, {59'b0, tag32}, {59'b0, tag});
    chk({name, "_vld64"}, {63'b0, vld64}, 64'd1);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_ill64"}, {63'b0, ill64}, {63'b0, e_ill64});
    @(negedge clk);
    chk({name, "_drain"}, {63'b0, vld32}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_ins = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy",  {63'b0, rdy32}, 64'd1);
    chk("rst_vld",  {63'b0, vld32}, 64'd0);
    chk("rst_imm",  {32'b0, imm32}, 64'd0);
    chk("rst_tag",  {59'b0, tag32}, 64'd0);
    chk("rst_ill",  {63'b0, ill32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Format vectors
    vec("I",   32'hFFF00093, 3'b000, 5'd7,  32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    vec("S",   32'h00A00423, 3'b001, 5'd8,  32'h00000008, 1'b0, 64'h0000000000000008, 1'b0);
    vec("B",   32'hFE000EE3, 3'b010, 5'd9,  32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("J",   32'hFFDFF06F, 3'b011, 5'd10, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("U",   32'h800000B7, 3'b100, 5'd11, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    vec("Z",   32'h000F8073, 3'b101, 5'd12, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
    vec("SH",  32'h03F00013, 3'b110, 5'd13, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0);
    vec("SHL", 32'h01F00013, 3'b110, 5'd14, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
    vec("RSV", 32'hFFFFFFFF, 3'b111, 5'd15, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1);

    // Backpressure: A,B,C back to back with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'b000;
    in_ins = 32'h00100013; in_tag = 5'd1;
    @(negedge clk);
    chk("bp_rdy_after_a", {63'b0, rdy32}, 64'd1);
    in_ins = 32'h00200013; in_tag = 5'd2;
    @(negedge clk);
    chk("bp_rdy_after_b", {63'b0, rdy32}, 64'd0);
    chk("bp_rdy64_after_b", {63'b0, rdy64}, 64'd0);
    chk("bp_hold_tag_a", {59'b0, tag32}, 64'd1);
    in_ins = 32'h00300013; in_tag = 5'd3;
    @(negedge clk);
    chk("bp_stall_rdy", {63'b0, rdy32}, 64'd0);
    chk("bp_stall_vld", {63'b0, vld32}, 64'd1);
    chk("bp_stall_tag", {59'b0, tag32}, 64'd1);
    chk("bp_stall_imm", {32'b0, imm32}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_tag2", {59'b0, tag32}, 64'd2);
    chk("bp_out_imm2", {32'b0, imm32}, 64'd2);
    chk("bp_rdy_again", {63'b0, rdy32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out_tag3", {59'b0, tag32}, 64'd3);
    chk("bp_out_imm3", {32'b0, imm32}, 64'd3);
    chk("bp_out_vld3", {63'b0, vld32}, 64'd1);
    @(negedge clk);
    chk("bp_empty", {63'b0, vld32}, 64'd0);

    // Flush in TWO with a beat presented
    out_ready = 1'b0;
    send(32'h00400013, 3'b000, 5'd4);
    send(32'h00500013, 3'b000, 5'd5);
    chk("fl_two_rdy", {63'b0, rdy32}, 64'd0);
    in_valid = 1'b1; in_ins = 32'h00600013; in_sel = 3'b000; in_tag = 5'd6;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", {63'b0, vld32}, 64'd0);
    chk("fl_rdy", {63'b0, rdy32}, 64'd1);
    chk("fl_vld64", {63'b0, vld64}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_ghost", {63'b0, vld32}, 64'd0);
    end

    // Async reset while in ONE
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 5'd9);
    chk("ar_one_vld", {63'b0, vld32}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", {63'b0, vld32}, 64'd0);
    chk("ar_imm", {32'b0, imm32}, 64'd0);
    chk("ar_tag", {59'b0, tag32}, 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    chk("ar_rdy", {63'b0, rdy32}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_ins = 32'h00700013; in_sel = 3'b000; in_tag = 5'd17;
    #1;
    chk("ar_pre_vld", {63'b0, vld32}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_lat_vld", {63'b0, vld32}, 64'd1);
    chk("ar_lat_imm", {32'b0, imm32}, 64'd7);
    chk("ar_lat_tag", {59'b0, tag32}, 64'd17);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
